// File: rtl/conj_mult_pkg.sv
// Shared constants and the round/saturate helper for the lag-D conjugate
// product pipeline.
package conj_mult_pkg;

  // Register stages from an accepted sample to valid_o
  localparam int unsigned PIPE_LAT = 3;
  // Widest supported sample / output width
  localparam int unsigned MAX_W    = 64;
  // Working width: full-precision difference plus rounding headroom
  localparam int unsigned ACC_W    = 2 * MAX_W + 2;

  // Round half up by 2^(shift-1), arithmetic shift right, clamp to out_w signed
  function automatic logic signed [MAX_W-1:0] round_sat(
    input logic signed [ACC_W-1:0] val,
    input int unsigned             shift,
    input int unsigned             out_w
  );
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] hi;
    logic signed [ACC_W-1:0] lo;
    acc = val;
    if (shift > 0) begin
      acc = acc + $signed(ACC_W'(1) << (shift - 1));
    end
    acc = acc >>> shift;
    hi  = $signed((ACC_W'(1) << (out_w - 1)) - ACC_W'(1));
    lo  = ~hi;
    if (acc > hi) begin
      return MAX_W'(hi);
    end else if (acc < lo) begin
      return MAX_W'(lo);
    end
    return MAX_W'(acc);
  endfunction

endpackage

// File: rtl/iq_delay_line.sv
// Circular I/Q history of depth LAG. Read port shows the sample written LAG
// advances ago; storage is not reset since warm-up masks stale content.
module iq_delay_line #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LAG   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    adv_i,
  input  logic signed [WIDTH-1:0] real_i,
  input  logic signed [WIDTH-1:0] imag_i,
  output logic signed [WIDTH-1:0] real_o,
  output logic signed [WIDTH-1:0] imag_o
);

  localparam int unsigned PTR_W = (LAG > 1) ? $clog2(LAG) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(LAG - 1);

  logic signed [WIDTH-1:0] mem_real_q [LAG];
  logic signed [WIDTH-1:0] mem_imag_q [LAG];
  logic [PTR_W-1:0]        ptr_d;
  logic [PTR_W-1:0]        ptr_q;

  // Oldest entry sits at the write pointer (read-before-write)
  assign real_o = mem_real_q[ptr_q];
  assign imag_o = mem_imag_q[ptr_q];

  // Pointer advances only on accepted samples and wraps LAG-1 -> 0
  always_comb begin
    ptr_d = ptr_q;
    if (adv_i) begin
      ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);
    end
  end

  // Pointer register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // History storage, overwritten in place on each accepted sample
  always_ff @(posedge clk) begin
    if (adv_i) begin
      mem_real_q[ptr_q] <= real_i;
      mem_imag_q[ptr_q] <= imag_i;
    end
  end

endmodule

// File: rtl/conj_c_mult_pipe.sv
// Three-stage x[n]*conj(x[n-LAG]) pipeline producing the scaled imaginary
// part. Define CONJ_MULT_REAL_OUT_EN to also produce the real part on real_o.
module conj_c_mult_pipe
  import conj_mult_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned OUT_WIDTH = 16,
  parameter int unsigned LAG       = 1,
  parameter int unsigned SHIFT     = 15
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear_i,
  input  logic                        valid_i,
  input  logic signed [WIDTH-1:0]     real_i,
  input  logic signed [WIDTH-1:0]     imag_i,
  output logic                        valid_o,
`ifdef CONJ_MULT_REAL_OUT_EN
  output logic signed [OUT_WIDTH-1:0] real_o,
`endif
  output logic signed [OUT_WIDTH-1:0] demod_o
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned DW    = 2 * WIDTH + 1;
  localparam int unsigned CNT_W = $clog2(LAG + 1);

  logic                    accept_c;
  logic signed [WIDTH-1:0] del_real;
  logic signed [WIDTH-1:0] del_imag;

  logic [CNT_W-1:0]        warm_d, warm_q;
  logic                    s1_vld_d, s1_vld_q;
  logic signed [WIDTH-1:0] s1_real_d, s1_real_q, s1_imag_d, s1_imag_q;
  logic signed [WIDTH-1:0] s1_dreal_d, s1_dreal_q, s1_dimag_d, s1_dimag_q;
  logic                    s2_vld_d, s2_vld_q;
  logic signed [PW-1:0]    p_qi_d, p_qi_q, p_iq_d, p_iq_q;
  logic                    valid_o_d, valid_o_q;
  logic signed [OUT_WIDTH-1:0] demod_d, demod_q;
`ifdef CONJ_MULT_REAL_OUT_EN
  logic signed [PW-1:0]    p_ii_d, p_ii_q, p_qq_d, p_qq_q;
  logic signed [OUT_WIDTH-1:0] real_d, real_q;
`endif

  // Clear wins over a simultaneous sample, which is then dropped entirely
  assign accept_c = valid_i & ~clear_i;

  iq_delay_line #(
    .WIDTH (WIDTH),
    .LAG   (LAG)
  ) u_delay (
    .clk    (clk),
    .rst    (rst),
    .adv_i  (accept_c),
    .real_i (real_i),
    .imag_i (imag_i),
    .real_o (del_real),
    .imag_o (del_imag)
  );

  // Warm-up count, stage capture, products and rounded/saturated result
  always_comb begin
    warm_d     = warm_q;
    s1_vld_d   = 1'b0;
    s1_real_d  = s1_real_q;
    s1_imag_d  = s1_imag_q;
    s1_dreal_d = s1_dreal_q;
    s1_dimag_d = s1_dimag_q;
    s2_vld_d   = 1'b0;
    p_qi_d     = p_qi_q;
    p_iq_d     = p_iq_q;
    valid_o_d  = 1'b0;
    demod_d    = demod_q;
`ifdef CONJ_MULT_REAL_OUT_EN
    p_ii_d     = p_ii_q;
    p_qq_d     = p_qq_q;
    real_d     = real_q;
`endif

    if (clear_i) begin
      warm_d = '0;
    end else if (accept_c && (warm_q != CNT_W'(LAG))) begin
      warm_d = warm_q + CNT_W'(1);
    end

    if (accept_c) begin
      s1_real_d  = real_i;
      s1_imag_d  = imag_i;
      s1_dreal_d = del_real;
      s1_dimag_d = del_imag;
      s1_vld_d   = (warm_q == CNT_W'(LAG));
    end

    if (s1_vld_q) begin
      p_qi_d   = PW'(s1_imag_q) * PW'(s1_dreal_q);
      p_iq_d   = PW'(s1_real_q) * PW'(s1_dimag_q);
`ifdef CONJ_MULT_REAL_OUT_EN
      p_ii_d   = PW'(s1_real_q) * PW'(s1_dreal_q);
      p_qq_d   = PW'(s1_imag_q) * PW'(s1_dimag_q);
`endif
      s2_vld_d = ~clear_i;
    end

    if (s2_vld_q && !clear_i) begin
      valid_o_d = 1'b1;
      demod_d   = OUT_WIDTH'(round_sat(ACC_W'(DW'(p_qi_q) - DW'(p_iq_q)), SHIFT, OUT_WIDTH));
`ifdef CONJ_MULT_REAL_OUT_EN
      real_d    = OUT_WIDTH'(round_sat(ACC_W'(DW'(p_ii_q) + DW'(p_qq_q)), SHIFT, OUT_WIDTH));
`endif
    end
  end

  // Pipeline registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      warm_q     <= '0;
      s1_vld_q   <= 1'b0;
      s1_real_q  <= '0;
      s1_imag_q  <= '0;
      s1_dreal_q <= '0;
      s1_dimag_q <= '0;
      s2_vld_q   <= 1'b0;
      p_qi_q     <= '0;
      p_iq_q     <= '0;
      valid_o_q  <= 1'b0;
      demod_q    <= '0;
`ifdef CONJ_MULT_REAL_OUT_EN
      p_ii_q     <= '0;
      p_qq_q     <= '0;
      real_q     <= '0;
`endif
    end else begin
      warm_q     <= warm_d;
      s1_vld_q   <= s1_vld_d;
      s1_real_q  <= s1_real_d;
      s1_imag_q  <= s1_imag_d;
      s1_dreal_q <= s1_dreal_d;
      s1_dimag_q <= s1_dimag_d;
      s2_vld_q   <= s2_vld_d;
      p_qi_q     <= p_qi_d;
      p_iq_q     <= p_iq_d;
      valid_o_q  <= valid_o_d;
      demod_q    <= demod_d;
`ifdef CONJ_MULT_REAL_OUT_EN
      p_ii_q     <= p_ii_d;
      p_qq_q     <= p_qq_d;
      real_q     <= real_d;
`endif
    end
  end

  assign valid_o = valid_o_q;
  assign demod_o = demod_q;
`ifdef CONJ_MULT_REAL_OUT_EN
  assign real_o  = real_q;
`endif

endmodule
